// File: rtl/varray_run_packer.sv
// Packs streamed (address, value) elements into runs of equal value at consecutive addresses.
// Optional build macro VARRAY_ZERO_SKIP_EN: zero-valued elements are skipped instead of packed.
module varray_run_packer #(
  parameter int VIRTUAL_ELEMENT_WIDTH = 18,
  parameter int VIRTUAL_ADDR_BITS     = 16,
  parameter int MAX_RUN               = 15
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [VIRTUAL_ADDR_BITS-1:0]     in_addr,
  input  logic [VIRTUAL_ELEMENT_WIDTH-1:0] in_dat,
  input  logic                             in_flush,
  input  logic                             out_stall,
  output logic                             we,
  output logic [VIRTUAL_ADDR_BITS-1:0]     write_addr,
  output logic [3:0]                       write_addr_len,
  output logic [VIRTUAL_ELEMENT_WIDTH-1:0] dat_w,
  output logic [15:0]                      run_count,
  output logic                             err_order
);

  localparam int AW = VIRTUAL_ADDR_BITS;
  localparam int DW = VIRTUAL_ELEMENT_WIDTH;
  localparam logic [3:0] MAX_LEN = 4'(MAX_RUN);

  // ST_FLUSH holds a single-element run that still has to be written out
  // (flush that also broke a run, or flush arriving in IDLE while stalled).
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   start_q, start_d;
  logic [3:0]      len_q, len_d;
  logic [DW-1:0]   dat_q, dat_d;
  logic            err_q, err_d;
  logic            we_q;
  logic [AW-1:0]   wr_addr_q;
  logic [3:0]      wr_len_q;
  logic [DW-1:0]   wr_dat_q;
  logic [15:0]     cnt_q;

  logic            hs_s, next_s, back_s, zero_s, extends_s;
  logic [AW:0]     end_s;
  logic            emit_s;
  logic [AW-1:0]   em_addr_s;
  logic [3:0]      em_len_s;
  logic [DW-1:0]   em_dat_s;

  // Extra top bit: a run touching the last address makes end_s unreachable by any in_addr.
  assign end_s  = {1'b0, start_q} + (AW+1)'(len_q);
  assign next_s = ({1'b0, in_addr} == end_s);
  assign back_s = ({1'b0, in_addr} < end_s);

`ifdef VARRAY_ZERO_SKIP_EN
  assign zero_s = (in_dat == {DW{1'b0}});
`else
  assign zero_s = 1'b0;
`endif

  assign extends_s = (state_q == ST_HOLD) && next_s && (in_dat == dat_q) &&
                     (len_q < MAX_LEN) && !zero_s;
  assign in_ready  = (state_q == ST_FLUSH) ? 1'b0 :
                     (!out_stall || (state_q == ST_IDLE) || (in_valid && extends_s && !in_flush));
  assign hs_s      = in_valid && in_ready;

  // Next-state, held-run update and emission request.
  always_comb begin
    state_d   = state_q;
    start_d   = start_q;
    len_d     = len_q;
    dat_d     = dat_q;
    err_d     = err_q;
    emit_s    = 1'b0;
    em_addr_s = start_q;
    em_len_s  = len_q;
    em_dat_s  = dat_q;
    case (state_q)
      ST_IDLE: begin
        if (hs_s && !zero_s) begin
          start_d = in_addr;
          len_d   = 4'd1;
          dat_d   = in_dat;
          if (!in_flush) begin
            state_d = ST_HOLD;
          end else if (out_stall) begin
            state_d = ST_FLUSH;
          end else begin
            emit_s    = 1'b1;
            em_addr_s = in_addr;
            em_len_s  = 4'd1;
            em_dat_s  = in_dat;
            len_d     = 4'd0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (!hs_s) begin
          state_d = ST_HOLD;
        end else if (back_s) begin
          err_d = 1'b1;
          if (in_flush) begin
            emit_s  = 1'b1;
            len_d   = 4'd0;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_HOLD;
          end
        end else if (zero_s) begin
          emit_s  = 1'b1;
          len_d   = 4'd0;
          state_d = ST_IDLE;
        end else if (extends_s) begin
          if (in_flush) begin
            emit_s   = 1'b1;
            em_len_s = len_q + 4'd1;
            len_d    = 4'd0;
            state_d  = ST_IDLE;
          end else begin
            len_d = len_q + 4'd1;
          end
        end else begin
          emit_s  = 1'b1;
          start_d = in_addr;
          len_d   = 4'd1;
          dat_d   = in_dat;
          state_d = in_flush ? ST_FLUSH : ST_HOLD;
        end
      end
      ST_FLUSH: begin
        if (!out_stall) begin
          emit_s  = 1'b1;
          len_d   = 4'd0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_FLUSH;
        end
      end
      default: begin
        state_d = ST_IDLE;
        len_d   = 4'd0;
      end
    endcase
  end

  // Held-run state and sticky order error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      start_q <= {AW{1'b0}};
      len_q   <= 4'd0;
      dat_q   <= {DW{1'b0}};
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      len_q   <= len_d;
      dat_q   <= dat_d;
      err_q   <= err_d;
    end
  end

  // Registered write port and emitted-run counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we_q      <= 1'b0;
      wr_addr_q <= {AW{1'b0}};
      wr_len_q  <= 4'd0;
      wr_dat_q  <= {DW{1'b0}};
      cnt_q     <= 16'd0;
    end else begin
      we_q <= emit_s;
      if (emit_s) begin
        wr_addr_q <= em_addr_s;
        wr_len_q  <= em_len_s;
        wr_dat_q  <= em_dat_s;
        cnt_q     <= cnt_q + 16'd1;
      end
    end
  end

  assign we             = we_q;
  assign write_addr     = wr_addr_q;
  assign write_addr_len = wr_len_q;
  assign dat_w          = wr_dat_q;
  assign run_count      = cnt_q;
  assign err_order      = err_q;

endmodule

// File: tb/tb_varray_run_packer.sv
// Scoreboard bench for varray_run_packer: expected runs are queued as stimulus is
// driven and compared as write strobes appear.
module tb_varray_run_packer;

  typedef struct packed {
    logic [15:0] a;
    logic [3:0]  l;
    logic [17:0] d;
  } run_t;

  logic        clk = 1'b0;
  logic        reset_n, in_valid, in_ready, in_flush, out_stall, we, err_order;
  logic [15:0] in_addr, write_addr, run_count;
  logic [17:0] in_dat, dat_w;
  logic [3:0]  write_addr_len;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_cnt = 0;
  bit   rnd_stall = 1'b0;
  run_t exp_q[$];

  always #5 clk = ~clk;

  varray_run_packer dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_dat(in_dat), .in_flush(in_flush), .out_stall(out_stall),
    .we(we), .write_addr(write_addr), .write_addr_len(write_addr_len), .dat_w(dat_w),
    .run_count(run_count), .err_order(err_order)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_run(input logic [15:0] a, input logic [3:0] l, input logic [17:0] d);
    run_t r;
    r.a = a; r.l = l; r.d = d;
    exp_q.push_back(r);
    exp_cnt++;
  endtask

  task automatic send(input logic [15:0] a, input logic [17:0] d, input bit f);
    int n = 0;
    in_valid = 1'b1; in_addr = a; in_dat = d; in_flush = f;
    if (rnd_stall) out_stall = 1'($urandom_range(0, 1));
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      if (rnd_stall) out_stall = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    if (!in_ready) check_eq("hs_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_flush = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    check_eq("drain_empty", 32'(exp_q.size()), 32'd0);
    check_eq("run_count", 32'(run_count), 32'(exp_cnt));
  endtask

  task automatic do_reset();
    reset_n = 1'b0; in_valid = 1'b0; in_flush = 1'b0; out_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    exp_cnt = 0;
    reset_n = 1'b1;
    #1;
    check_eq("ready_after_rst", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
  endtask

  // Compare every write strobe against the head of the scoreboard.
  always @(negedge clk) begin : mon
    run_t e;
    if (reset_n && we) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_we", 32'(write_addr), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check_eq("wr_addr", 32'(write_addr), 32'(e.a));
        check_eq("wr_len", 32'(write_addr_len), 32'(e.l));
        check_eq("wr_dat", 32'(dat_w), 32'(e.d));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_addr = 16'd0; in_dat = 18'd0;
    in_flush = 1'b0; out_stall = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_we", 32'(we), 32'd0);
    check_eq("rst_addr", 32'(write_addr), 32'd0);
    check_eq("rst_len", 32'(write_addr_len), 32'd0);
    check_eq("rst_dat", 32'(dat_w), 32'd0);
    check_eq("rst_count", 32'(run_count), 32'd0);
    check_eq("rst_err", 32'(err_order), 32'd0);
    reset_n = 1'b1;
    #1;
    check_eq("ready_after_rst", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Five consecutive equal values, flush on the last.
    expect_run(16'd0, 4'd5, 18'd7);
    for (int i = 0; i < 5; i++) send(16'(i), 18'd7, i == 4);
    drain();

    // Length limit splits a 20-element run.
    do_reset();
    expect_run(16'd0, 4'd15, 18'd3);
    expect_run(16'd15, 4'd5, 18'd3);
    for (int i = 0; i < 20; i++) send(16'(i), 18'd3, i == 19);
    drain();

    // Address gap breaks the run; flush on the breaking element emits both.
    expect_run(16'd10, 4'd1, 18'd1);
    expect_run(16'd12, 4'd1, 18'd1);
    send(16'd10, 18'd1, 1'b0);
    send(16'd12, 18'd1, 1'b1);
    drain();

    // Stall: extension still accepted, breaking element held off until release.
    expect_run(16'd20, 4'd2, 18'd9);
    out_stall = 1'b1;
    send(16'd20, 18'd9, 1'b0);
    send(16'd21, 18'd9, 1'b0);
    in_valid = 1'b1; in_addr = 16'd30; in_dat = 18'd9; in_flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("stall_ready", 32'(in_ready), 32'd0);
      check_eq("stall_we", 32'(we), 32'd0);
      @(posedge clk); #1;
    end
    out_stall = 1'b0;
    @(negedge clk);
    check_eq("unstall_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    expect_run(16'd30, 4'd2, 18'd9);
    send(16'd31, 18'd9, 1'b1);
    drain();

    // Flush in IDLE while stalled is deferred until the stall clears.
    expect_run(16'd40, 4'd1, 18'd1);
    out_stall = 1'b1;
    send(16'd40, 18'd1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("idle_flush_stall_we", 32'(we), 32'd0);
      @(posedge clk); #1;
    end
    out_stall = 1'b0;
    drain();

    // Run ending at the top of the address space.
    expect_run(16'hFFFE, 4'd2, 18'd1);
    send(16'hFFFE, 18'd1, 1'b0);
    send(16'hFFFF, 18'd1, 1'b1);
    drain();

    // Random stall toggling over runs of three.
    for (int k = 0; k < 13; k++) expect_run(16'(100 + 3 * k), 4'd3, 18'(k + 1));
    expect_run(16'd139, 4'd1, 18'd14);
    rnd_stall = 1'b1;
    for (int i = 0; i < 40; i++) send(16'(100 + i), 18'(i / 3 + 1), i == 39);
    rnd_stall = 1'b0;
    out_stall = 1'b0;
    drain();
    check_eq("rnd_err", 32'(err_order), 32'd0);

    // Zero elements: skipped or packed depending on build.
    do_reset();
`ifdef VARRAY_ZERO_SKIP_EN
    expect_run(16'd0, 4'd1, 18'd2);
    expect_run(16'd3, 4'd1, 18'd2);
`else
    expect_run(16'd0, 4'd1, 18'd2);
    expect_run(16'd1, 4'd2, 18'd0);
    expect_run(16'd3, 4'd1, 18'd2);
`endif
    send(16'd0, 18'd2, 1'b0);
    send(16'd1, 18'd0, 1'b0);
    send(16'd2, 18'd0, 1'b0);
    send(16'd3, 18'd2, 1'b1);
    drain();

    // Reset with a run held discards it.
    send(16'd50, 18'd5, 1'b0);
    do_reset();
    drain();

    // Backward address: dropped, sticky error, held run flushed unchanged.
    check_eq("err_clear", 32'(err_order), 32'd0);
    expect_run(16'd5, 4'd1, 18'd4);
    send(16'd5, 18'd4, 1'b0);
    send(16'd3, 18'd4, 1'b1);
    drain();
    check_eq("err_set", 32'(err_order), 32'd1);
    send(16'd60, 18'd4, 1'b0);
    check_eq("err_sticky", 32'(err_order), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/varray_run_packer.md
VARRAY_RUN_PACKER -- requirements
Module: varray_run_packer

Interface
REQ-001 Parameter VIRTUAL_ELEMENT_WIDTH, default 18, element data width.
REQ-002 Parameter VIRTUAL_ADDR_BITS, default 16, virtual address width.
REQ-003 Parameter MAX_RUN, default 15, maximum run length; SHALL be 1..15 to fit write_addr_len.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  input element valid.
REQ-007 in_ready  output  1  block accepts the element this cycle.
REQ-008 in_addr  input  VIRTUAL_ADDR_BITS  element virtual address.
REQ-009 in_dat  input  VIRTUAL_ELEMENT_WIDTH  element value.
REQ-010 in_flush  input  1  qualified by in_valid and in_ready; emit the held run after absorbing this element.
REQ-011 out_stall  input  1  downstream array cannot take a write this cycle.
REQ-012 we  output  1  one-cycle write strobe to the downstream array.
REQ-013 write_addr  output  VIRTUAL_ADDR_BITS  run start address.
REQ-014 write_addr_len  output  4  run length.
REQ-015 dat_w  output  VIRTUAL_ELEMENT_WIDTH  run value.
REQ-016 run_count  output  16  runs emitted, wraps at 65535 to 0.
REQ-017 err_order  output  1  sticky: non-monotonic address seen.

Function
REQ-018 Held-run registers: start S, length L, value D; states IDLE (no run held) and HOLD (run held).
REQ-019 A handshake occurs when in_valid and in_ready are both 1; the element is "next" when in_addr == S+L (computed at VIRTUAL_ADDR_BITS+1 width).
REQ-020 In IDLE, a handshake loads S=in_addr, L=1, D=in_dat and goes to HOLD.
REQ-021 In HOLD, a handshake with a next element, in_dat==D and L<MAX_RUN increments L.
REQ-022 Otherwise, in HOLD, a handshake emits (S,L,D) and loads the new element as L=1 in the same cycle.
REQ-023 A handshake with in_flush emits the run including this element and goes to IDLE.
REQ-024 Emission: we=1 with write_addr/write_addr_len/dat_w registered, one cycle after the handshake; we is 0 in every other cycle.
REQ-025 in_ready = !out_stall || state==IDLE || (in_valid extends the run and in_flush==0).
REQ-026 No emission occurs while out_stall=1; out_stall toggling never drops or duplicates a run.
REQ-027 In HOLD with in_addr < S+L, the element is accepted and discarded, err_order is set, and the held run is unchanged.
REQ-028 A run never extends past address 2^VIRTUAL_ADDR_BITS-1; S+L overflow forces the element to start a new run.
REQ-029 run_count increments once per we pulse.
REQ-030 Emitted write_addr sequence is strictly increasing and runs never overlap.

Reset
REQ-031 While reset_n=0: state=IDLE, S=0, L=0, D=0, we=0, write_addr=0, write_addr_len=0, dat_w=0, run_count=0, err_order=0.
REQ-032 Reset mid-run discards the held run without emitting it; in_ready is 1 on the first cycle after release.

Configuration
REQ-033 Macro VARRAY_ZERO_SKIP_EN.
REQ-034 Defined: in_dat==0 elements are accepted without being packed; a held run is emitted on such a handshake (if out_stall=0, else in_ready=0). A flush on a zero element emits the held run, if any. Gaps read back as 0 downstream.
REQ-035 Undefined: zero elements are packed like any other value.

Verification
REQ-036 Addrs 0..4, dat 7, flush on 4 -> one we: addr 0, len 5, dat 7; run_count=1.
REQ-037 Addrs 0..19, dat 3, flush on 19 -> we (0,15,3) then (15,5,3).
REQ-038 Addr 10 dat 1, then addr 12 dat 1, flush -> (10,1,1) then (12,1,1).
REQ-039 Run held, out_stall=1, breaking element -> in_ready=0 until out_stall=0, then single we, no loss.
REQ-040 Addr 5 then addr 3 -> err_order=1, addr 3 dropped, flush emits (5,1,x).
REQ-041 VARRAY_ZERO_SKIP_EN: addrs 0..3, dat 2,0,0,2, flush on 3 -> (0,1,2), (3,1,2); without the macro -> (0,1,2), (1,2,0), (3,1,2).
